// File: rtl/rib_pkg.sv
// rib_pkg -- shared types and helpers for the bus arbiter slice.
//   arb_state_t : arbiter FSM states (ST_IDLE, ST_GRANT)
//   hold_t      : hold flag encoding (HoldDisable, HoldEnable)
//   id_width()  : bit width of a master ID for n masters (minimum 1)
package rib_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  typedef enum logic {
    HoldDisable = 1'b0,
    HoldEnable  = 1'b1
  } hold_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin winner selection.
//   i_req    : request vector, one bit per master
//   i_start  : index to start searching from (searches upward, wraps)
//   o_valid  : high when any request bit is set
//   o_winner : first requesting index at or after i_start
module rr_pick
  import rib_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = id_width(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic         o_valid,
  output logic [W-1:0] o_winner
);

  logic [W-1:0] w_idx;

  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = W'((32'(i_start) + i) % N);
      if (!o_valid && i_req[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter -- round-robin bus arbiter with registered one-hot grant.
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   req_i       : per-master level request
//   done_i      : per-master end-of-transaction strobe (owner's bit only)
//   gnt_o       : registered one-hot grant, zero when idle
//   owner_o     : registered current/last owner ID
//   busy_o      : high while granting
//   hold_flag_o : high while granted to a master other than FETCH_MASTER
//   timeout_o   : one-cycle pulse on forced release
// Optional feature: define ARB_TIMEOUT_EN to bound grant tenure to
// TIMEOUT_CYCLES cycles; otherwise tenure is unbounded and timeout_o is 0.
module bus_arbiter
  import rib_pkg::*;
#(
  parameter int unsigned N_MASTERS      = 4,
  parameter int unsigned FETCH_MASTER   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_MASTERS-1:0]                req_i,
  input  logic [N_MASTERS-1:0]                done_i,
  output logic [N_MASTERS-1:0]                gnt_o,
  output logic [id_width(N_MASTERS)-1:0]      owner_o,
  output logic                                busy_o,
  output logic                                hold_flag_o,
  output logic                                timeout_o
);

  localparam int unsigned W = id_width(N_MASTERS);

  arb_state_t           r_state;
  logic [N_MASTERS-1:0] r_gnt;
  logic [W-1:0]         r_owner;
  logic                 r_busy;
  hold_t                r_hold;

  logic [W-1:0]         w_start;
  logic [N_MASTERS-1:0] w_cand;
  logic                 w_valid;
  logic [W-1:0]         w_winner;
  logic [N_MASTERS-1:0] w_onehot;
  logic                 w_rel_nat;
  logic                 w_tmo;
  logic                 w_release;

  // Search always begins just past the last owner; the owner register
  // doubles as the round-robin pointer.
  assign w_start = (r_owner == W'(N_MASTERS - 1)) ? '0 : r_owner + W'(1);

  // While granting, the current owner is excluded so a releasing master
  // cannot win the same edge it lets go.
  always_comb begin
    w_cand = req_i;
    if (r_state == ST_GRANT) w_cand[r_owner] = 1'b0;
  end

  always_comb begin
    w_onehot           = '0;
    w_onehot[w_winner] = 1'b1;
  end

  assign w_rel_nat = done_i[r_owner] || !req_i[r_owner];
  assign w_release = w_rel_nat || w_tmo;

  rr_pick #(
    .N (N_MASTERS),
    .W (W)
  ) u_pick (
    .i_req    (w_cand),
    .i_start  (w_start),
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_owner <= W'(N_MASTERS - 1);
      r_busy  <= 1'b0;
      r_hold  <= HoldDisable;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_state <= ST_GRANT;
            r_gnt   <= w_onehot;
            r_owner <= w_winner;
            r_busy  <= 1'b1;
            r_hold  <= (w_winner != W'(FETCH_MASTER)) ? HoldEnable : HoldDisable;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            if (w_valid) begin
              r_gnt   <= w_onehot;
              r_owner <= w_winner;
              r_hold  <= (w_winner != W'(FETCH_MASTER)) ? HoldEnable : HoldDisable;
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= '0;
              r_busy  <= 1'b0;
              r_hold  <= HoldDisable;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_tenure;
  logic          r_timeout;

  assign w_tmo = (r_state == ST_GRANT) && (r_tenure == CW'(TIMEOUT_CYCLES - 1));

  // Tenure restarts on every grant change or idle; the pulse is raised
  // only when the timeout alone caused the release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tenure  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo && !w_rel_nat;
      if ((r_state == ST_GRANT) && !w_release) r_tenure <= r_tenure + CW'(1);
      else                                     r_tenure <= '0;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_tmo     = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign gnt_o       = r_gnt;
  assign owner_o     = r_owner;
  assign busy_o      = r_busy;
  assign hold_flag_o = (r_hold == HoldEnable);

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int FM = 1;
  localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_i;
  logic [N-1:0] done_i;
  logic [N-1:0] gnt_o;
  logic [1:0]   owner_o;
  logic         busy_o;
  logic         hold_flag_o;
  logic         timeout_o;

  int errors = 0;
  int checks = 0;

  bus_arbiter #(
    .N_MASTERS      (N),
    .FETCH_MASTER   (FM),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .done_i      (done_i),
    .gnt_o       (gnt_o),
    .owner_o     (owner_o),
    .busy_o      (busy_o),
    .hold_flag_o (hold_flag_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester strictly after 'from', wrapping around.
  function automatic int scan(input logic [N-1:0] v, input int from);
    for (int k = 1; k <= N; k++)
      if (v[(from + k) % N]) return (from + k) % N;
    return from;
  endfunction

  // Reference model: who owns the bus, and for how many cycles so far.
  logic m_busy  = 1'b0;
  int   m_owner = N - 1;
  int   m_ten   = 0;
  logic m_tmo   = 1'b0;
  bit   m_live  = 1'b0;

  always @(posedge clk) begin : model
    int o; int t; logic b; logic tm; logic nat; logic frc; logic [N-1:0] oth;
    o = m_owner; t = m_ten; b = m_busy; tm = 1'b0;
    if (!rst_n) begin
      b = 1'b0; o = N - 1; t = 0;
    end else if (!b) begin
      if (req_i != '0) begin
        o = scan(req_i, o); b = 1'b1; t = 1;
      end
    end else begin
      nat = done_i[o] || !req_i[o];
      frc = TMO_ON && (t == TO);
      if (nat || frc) begin
        tm  = frc && !nat;
        oth = req_i;
        oth[o] = 1'b0;
        if (oth != '0) begin
          o = scan(oth, o); t = 1;
        end else begin
          b = 1'b0; t = 0;
        end
      end else begin
        t = t + 1;
      end
    end
    m_busy  <= b;
    m_owner <= o;
    m_ten   <= t;
    m_tmo   <= tm;
    m_live  <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("gnt",     32'(gnt_o),       m_busy ? 32'(1 << m_owner) : 32'd0);
      chk("owner",   32'(owner_o),     32'(m_owner));
      chk("busy",    32'(busy_o),      32'(m_busy));
      chk("hold",    32'(hold_flag_o), 32'(m_busy && (m_owner != FM)));
      chk("timeout", 32'(timeout_o),   32'(m_tmo));
      chk("onehot",  32'($countones(gnt_o) <= 1), 32'd1);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_i = '0; done_i = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_i = '0; done_i = '0;
    tick(); tick();
    chk("rst_gnt",   32'(gnt_o),       32'd0);
    chk("rst_owner", 32'(owner_o),     32'd3);
    chk("rst_busy",  32'(busy_o),      32'd0);
    chk("rst_hold",  32'(hold_flag_o), 32'd0);
    chk("rst_tmo",   32'(timeout_o),   32'd0);

    // Single request: grant exactly one cycle later.
    rst_n = 1'b1; req_i = 4'b0100;
    tick();
    chk("lat_gnt",   32'(gnt_o),       32'h4);
    chk("lat_owner", 32'(owner_o),     32'd2);
    chk("lat_busy",  32'(busy_o),      32'd1);
    chk("lat_hold",  32'(hold_flag_o), 32'd1);

    // All request, owners pulse done: 0,1,2,3,0 back to back.
    do_reset();
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_owner", 32'(owner_o), 32'(k % 4));
      chk("rr_busy",  32'(busy_o),  32'd1);
      done_i = 4'(1 << (k % 4));
    end
    done_i = '0;

    // Fetch master alone: never holds.
    do_reset();
    req_i = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fetch_gnt",  32'(gnt_o),       32'h2);
      chk("fetch_hold", 32'(hold_flag_o), 32'd0);
    end

    // Master 3 done with request still high: one idle cycle, then regrant.
    do_reset();
    req_i = 4'b1000;
    tick();
    chk("m3_gnt", 32'(gnt_o), 32'h8);
    done_i = 4'b1000;
    tick();
    chk("m3_idle_gnt",  32'(gnt_o),  32'd0);
    chk("m3_idle_busy", 32'(busy_o), 32'd0);
    done_i = '0;
    tick();
    chk("m3_regnt", 32'(gnt_o), 32'h8);

    // Reset in mid-grant.
    do_reset();
    req_i = 4'b0100;
    tick();
    chk("mr_gnt", 32'(gnt_o), 32'h4);
    rst_n = 1'b0;
    tick();
    chk("mr_rst_gnt",   32'(gnt_o),   32'd0);
    chk("mr_rst_owner", 32'(owner_o), 32'd3);
    rst_n = 1'b1;
    tick();
    chk("mr_regnt", 32'(gnt_o), 32'h4);

`ifdef ARB_TIMEOUT_EN
    // Master 0 never finishes; master 2 waits; forced handoff after 8 cycles.
    do_reset();
    req_i = 4'b0001;
    tick();
    req_i = 4'b0101;
    chk("to_owner0", 32'(owner_o), 32'd0);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("to_hold_owner", 32'(owner_o),   32'd0);
      chk("to_no_pulse",   32'(timeout_o), 32'd0);
    end
    tick();
    chk("to_owner2", 32'(owner_o),   32'd2);
    chk("to_pulse",  32'(timeout_o), 32'd1);
    tick();
    chk("to_pulse_end", 32'(timeout_o), 32'd0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(5) == 0) req_i[b] = ~req_i[b];
      for (int b = 0; b < N; b++)
        done_i[b] = ($urandom_range(5) == 0);
      rst_n = ($urandom_range(99) != 0);
      tick();
    end

    rst_n = 1'b1; req_i = '0; done_i = '0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
